// File: rtl/execute_muldiv_if.sv
// Handshake and operand/result bundle between decode, the M-extension unit and writeback.
// The unit sits on the slave side; decode/writeback drive the master side.
interface execute_muldiv_if #(
    parameter int XLEN = 32
);
    logic            prev_valid_i;
    logic            self_ready_o;
    logic            self_valid_o;
    logic            next_ready_i;
    logic            flush_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            busy_o;

    modport slave (
        input  prev_valid_i, next_ready_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
        output self_ready_o, self_valid_o, result_o, rd_o, busy_o
    );

    modport master (
        output prev_valid_i, next_ready_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
        input  self_ready_o, self_valid_o, result_o, rd_o, busy_o
    );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV-M mul/div: XLEN+1 cycles from accept to valid (1 for divide corner cases).
// Result held in DONE until next_ready_i; no accept until back in IDLE; flush_i wins everywhere.
module execute_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    execute_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg, sign_in;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN-1:0]   min_neg;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN:0]     rem_sh, diff, rem_step;
    logic              div_ge;
    logic [XLEN-1:0]   quo_step, quo_fix, rem_fix, final_res;

    assign min_neg = {1'b1, {(XLEN-1){1'b0}}};
    assign accept  = (state_q == IDLE) && bus.prev_valid_i && !bus.flush_i;

    // Operand decode: iterate on magnitudes, remember whether to negate at the end.
    always_comb begin
        a_signed    = 1'b0;
        b_signed    = 1'b0;
        sign_in     = 1'b0;
        special_res = '0;
        case (bus.funct3_i)
            3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'd2:             a_signed = 1'b1;
            default:          ;
        endcase
        a_neg = a_signed && bus.rs1_i[XLEN-1];
        b_neg = b_signed && bus.rs2_i[XLEN-1];
        a_mag = a_neg ? -bus.rs1_i : bus.rs1_i;
        b_mag = b_neg ? -bus.rs2_i : bus.rs2_i;
        case (bus.funct3_i)
            3'd1, 3'd4:  sign_in = a_neg ^ b_neg;
            3'd2, 3'd6:  sign_in = a_neg;
            default:     sign_in = 1'b0;
        endcase
        div_zero = bus.funct3_i[2] && (bus.rs2_i == '0);
        div_ovf  = bus.funct3_i[2] && !bus.funct3_i[0] &&
                   (bus.rs1_i == min_neg) && (bus.rs2_i == '1);
        if (div_zero)
            special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        else if (div_ovf)
            special_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
    end

    // One radix-2 step of each datapath, plus sign fix-up of the would-be final value.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        acc_step = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = sign_q ? -acc_step : acc_step;

        rem_sh   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        diff     = rem_sh - {1'b0, b_q};
        div_ge   = !diff[XLEN];
        rem_step = div_ge ? diff : rem_sh;
        quo_step = {quo_q[XLEN-2:0], div_ge};
        quo_fix  = sign_q ? -quo_step : quo_step;
        rem_fix  = sign_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];

        case (funct3_q)
            3'd0:             final_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quo_fix;
            default:          final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        sign_d   = sign_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = bus.funct3_i;
                    rd_d     = bus.rd_i;
                    sign_d   = sign_in;
                    b_d      = b_mag;
                    acc_d    = {{XLEN{1'b0}}, a_mag};
                    rem_d    = '0;
                    quo_d    = a_mag;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = acc_step;
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.next_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            sign_q   <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            sign_q   <= sign_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign bus.self_ready_o = (state_q == IDLE) && !bus.flush_i;
    assign bus.self_valid_o = (state_q == DONE);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.result_o     = result_q;
    assign bus.rd_o         = rd_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed plus randomized checks of execute_muldiv against a 64-bit arithmetic reference.
module tb_execute_muldiv;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    execute_muldiv_if #(.XLEN(32)) bus ();
    execute_muldiv #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (f3)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            3'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r  = sp[63:32];
            end
            3'd2: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
                r  = sp[63:32];
            end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sb;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = sa % sb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        chk("ready_idle", bus.self_ready_o, 1);
        bus.prev_valid_i = 1'b1;
        bus.funct3_i     = f3;
        bus.rs1_i        = a;
        bus.rs2_i        = b;
        bus.rd_i         = rd;
        @(posedge clk);
        @(negedge clk);
        bus.prev_valid_i = 1'b0;
        bus.funct3_i     = 3'($urandom);
        bus.rs1_i        = $urandom;
        bus.rs2_i        = $urandom;
        bus.rd_i         = 5'($urandom);
        chk("busy_after_accept", bus.busy_o, 1);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold);
        logic [31:0] exp;
        int          lat;
        exp = ref_model(f3, a, b);
        start_op(f3, a, b, rd);
        lat = 1;
        while (!bus.self_valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_latency(f3, a, b)));
        chk("result", bus.result_o, exp);
        chk("rd", bus.rd_o, rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.self_valid_o, 1);
            chk("hold_ready", bus.self_ready_o, 0);
            chk("hold_result", bus.result_o, exp);
            chk("hold_rd", bus.rd_o, rd);
        end
        bus.next_ready_i = 1'b1;
        @(negedge clk);
        bus.next_ready_i = 1'b0;
        chk("idle_after_take", bus.busy_o, 0);
        chk("valid_dropped", bus.self_valid_o, 0);
    endtask

    task automatic watch_no_valid(input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.self_valid_o) seen++;
        end
        chk("no_valid_after_kill", 64'(seen), 0);
    endtask

    initial begin
        bus.prev_valid_i = 1'b0;
        bus.next_ready_i = 1'b0;
        bus.flush_i      = 1'b0;
        bus.funct3_i     = '0;
        bus.rs1_i        = '0;
        bus.rs2_i        = '0;
        bus.rd_i         = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_result", bus.result_o, 0);
        chk("rst_rd", bus.rd_o, 0);
        chk("rst_valid", bus.self_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_ready", bus.self_ready_o, 1);

        run_op(3'd0, 32'd7, 32'd6, 5'd11, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        run_op(3'd4, -32'sd7, 32'd2, 5'd4, 0);
        run_op(3'd6, -32'sd7, 32'd2, 5'd5, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd6, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd7, 0);
        run_op(3'd4, 32'd1234, 32'd0, 5'd8, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd9, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        run_op(3'd0, 32'd123, 32'd456, 5'd13, 5);

        // Flush at CALC cycle 10, then a normal op must still work.
        start_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd14);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        chk("ready_masked_by_flush", bus.self_ready_o, 0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_busy", bus.busy_o, 0);
        chk("flush_valid", bus.self_valid_o, 0);
        watch_no_valid(40);
        run_op(3'd5, 32'd9, 32'd3, 5'd15, 0);

        // Reset at CALC cycle 10.
        start_op(3'd3, 32'hCAFE_F00D, 32'h0BAD_0BAD, 5'd16);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_result", bus.result_o, 0);
        chk("midrst_rd", bus.rd_o, 0);
        watch_no_valid(40);
        run_op(3'd5, 32'd9, 32'd3, 5'd17, 0);

        // Flush wins over next_ready in DONE, and flush blocks acceptance in IDLE.
        start_op(3'd5, 32'd50, 32'd0, 5'd18);
        chk("special_valid", bus.self_valid_o, 1);
        bus.flush_i      = 1'b1;
        bus.next_ready_i = 1'b1;
        bus.prev_valid_i = 1'b1;
        bus.funct3_i     = 3'd0;
        @(negedge clk);
        chk("flush_done_valid", bus.self_valid_o, 0);
        @(negedge clk);
        chk("flush_blocks_accept", bus.busy_o, 0);
        bus.flush_i      = 1'b0;
        bus.next_ready_i = 1'b0;
        bus.prev_valid_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(f3, a, b, 5'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
